// File: rtl/layer_output_serializer_pkg.sv
// Shared definitions for the layer-to-layer output serializer.
//   state_e   : FSM state encoding (IDLE=0, SHIFT=1)
//   cnt_width : word-counter width for a given neuron count, never below 1
package layer_output_serializer_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  // A single neuron still needs a 1-bit counter so the declaration stays legal.
  function automatic int unsigned cnt_width(input int unsigned num_neuron);
    return (num_neuron <= 1) ? 1 : $clog2(num_neuron);
  endfunction

endpackage

// File: rtl/layer_output_serializer.sv
// Layer output serializer.
// Captures the parallel outputs of one neuron layer when their outvalid strobes
// fire and replays them one word per cycle to the next layer's myinput port.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_data          : concatenated neuron outputs, neuron k at [k*dataWidth +: dataWidth]
//   i_valid         : per-neuron outvalid strobes; bit 0 is the capture reference
//   o_data          : serialized word (qualify with o_valid)
//   o_valid         : next layer's myinputValid
//   o_busy          : high while streaming
//   o_err_mismatch  : sticky, strobes not all equal in some cycle
//   o_err_overrun   : sticky, capture request dropped mid-stream
module layer_output_serializer
  import layer_output_serializer_pkg::*;
#(
  parameter int unsigned numNeuron = 30,
  parameter int unsigned dataWidth = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numNeuron*dataWidth-1:0] i_data,
  input  logic [numNeuron-1:0]           i_valid,
  output logic [dataWidth-1:0]           o_data,
  output logic                           o_valid,
  output logic                           o_busy,
  output logic                           o_err_mismatch,
  output logic                           o_err_overrun
);

  localparam int unsigned    CntW    = cnt_width(numNeuron);
  localparam logic [CntW-1:0] LastCnt = CntW'(numNeuron - 1);

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [dataWidth-1:0] buf_q [numNeuron];

  logic            cap_req;
  logic            strobe_mismatch;
  logic            last_word;
  logic            accept;
  logic [CntW-1:0] cnt_inc;

  assign cap_req         = i_valid[0];
  // Any mix of set and clear strobes, whether or not neuron 0 is among the set ones.
  assign strobe_mismatch = (i_valid != '0) && (i_valid != '1);
  assign last_word       = (cnt_q == LastCnt);
  // A capture in the final SHIFT cycle chains straight into the next stream.
  assign accept          = cap_req && ((state_q == StIdle) || last_word);
  assign cnt_inc         = cnt_q + CntW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      o_data         <= '0;
      o_valid        <= 1'b0;
      o_busy         <= 1'b0;
      o_err_mismatch <= 1'b0;
      o_err_overrun  <= 1'b0;
    end else begin
      if (strobe_mismatch) begin
        o_err_mismatch <= 1'b1;
      end
      if (cap_req && (state_q == StShift) && !last_word) begin
        o_err_overrun <= 1'b1;
      end

      if (accept) begin
        for (int unsigned k = 0; k < numNeuron; k++) begin
          buf_q[k] <= i_data[k*dataWidth +: dataWidth];
        end
        cnt_q   <= '0;
        o_data  <= i_data[dataWidth-1:0];
        o_valid <= 1'b1;
        o_busy  <= 1'b1;
        state_q <= StShift;
      end else if (state_q == StShift) begin
        if (!last_word) begin
          cnt_q  <= cnt_inc;
          o_data <= buf_q[cnt_inc];
        end else begin
          // o_data keeps its last word; o_valid drop marks it stale.
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_output_serializer.sv
module tb_layer_output_serializer;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          nchecks = 0;
  int          nerr = 0;

  // numNeuron = 4 instance
  logic        rst4;
  logic [63:0] i_data4;
  logic [3:0]  i_valid4;
  logic [15:0] o_data4;
  logic        o_valid4, o_busy4, o_mis4, o_ovr4;

  // numNeuron = 1 instance
  logic        rst1;
  logic [15:0] i_data1;
  logic [0:0]  i_valid1;
  logic [15:0] o_data1;
  logic        o_valid1, o_busy1, o_mis1, o_ovr1;

  exp_t q4[$];
  exp_t q1[$];

  layer_output_serializer #(.numNeuron(4), .dataWidth(16)) u_dut4 (
    .clk            (clk),
    .rst            (rst4),
    .i_data         (i_data4),
    .i_valid        (i_valid4),
    .o_data         (o_data4),
    .o_valid        (o_valid4),
    .o_busy         (o_busy4),
    .o_err_mismatch (o_mis4),
    .o_err_overrun  (o_ovr4)
  );

  layer_output_serializer #(.numNeuron(1), .dataWidth(16)) u_dut1 (
    .clk            (clk),
    .rst            (rst1),
    .i_data         (i_data1),
    .i_valid        (i_valid1),
    .o_data         (o_data1),
    .o_valid        (o_valid1),
    .o_busy         (o_busy1),
    .o_err_mismatch (o_mis1),
    .o_err_overrun  (o_ovr1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Words of a capture sampled on the next edge appear after edges cyc+1 .. cyc+n.
  task automatic push4(input logic [63:0] d, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.cyc  = cyc + 1 + k;
      e.data = d[k*16 +: 16];
      q4.push_back(e);
    end
  endtask

  task automatic push1(input logic [15:0] d);
    exp_t e;
    e.cyc  = cyc + 1;
    e.data = d;
    q1.push_back(e);
  endtask

  task automatic reset4();
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
  endtask

  // Monitor: every valid word must be the next expected one, on its expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (o_valid4 === 1'b1) begin
      if (q4.size() == 0) begin
        nchecks++;
        nerr++;
        $display("FAIL n4_unexpected_valid: got data %0h with nothing expected (cycle %0d)",
                 o_data4, cyc);
      end else begin
        e = q4.pop_front();
        chk("n4_word_cycle", cyc, e.cyc);
        chk("n4_word_data", {16'h0, o_data4}, {16'h0, e.data});
      end
    end
    if (o_valid1 === 1'b1) begin
      if (q1.size() == 0) begin
        nchecks++;
        nerr++;
        $display("FAIL n1_unexpected_valid: got data %0h with nothing expected (cycle %0d)",
                 o_data1, cyc);
      end else begin
        e = q1.pop_front();
        chk("n1_word_cycle", cyc, e.cyc);
        chk("n1_word_data", {16'h0, o_data1}, {16'h0, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    rst4 = 1'b1; rst1 = 1'b1;
    i_data4 = '0; i_valid4 = '0;
    i_data1 = '0; i_valid1 = '0;
    tick();
    tick();
    rst4 = 1'b0; rst1 = 1'b0;

    chk("reset_valid", o_valid4, 1'b0);
    chk("reset_busy", o_busy4, 1'b0);
    chk("reset_data", o_data4, 16'h0);
    chk("reset_mismatch", o_mis4, 1'b0);
    chk("reset_overrun", o_ovr4, 1'b0);
    chk("reset_n1_valid", o_valid1, 1'b0);

    // Single result
    i_valid4 = 4'hF; i_data4 = 64'h0004_0003_0002_0001;
    push4(i_data4, 4);
    tick();
    i_valid4 = 4'h0; i_data4 = '0;
    chk("single_busy", o_busy4, 1'b1);
    repeat (5) tick();
    chk("single_busy_end", o_busy4, 1'b0);
    chk("single_mismatch", o_mis4, 1'b0);
    chk("single_overrun", o_ovr4, 1'b0);

    // Back-to-back: second capture in the last SHIFT cycle
    i_valid4 = 4'hF; i_data4 = 64'h0004_0003_0002_0001;
    push4(i_data4, 4);
    tick();
    i_valid4 = 4'h0;
    repeat (3) tick();
    i_valid4 = 4'hF; i_data4 = 64'h0008_0007_0006_0005;
    push4(i_data4, 4);
    tick();
    i_valid4 = 4'h0;
    repeat (6) tick();
    chk("b2b_overrun", o_ovr4, 1'b0);
    chk("b2b_busy_end", o_busy4, 1'b0);

    // Overrun: second capture mid-stream is dropped
    reset4();
    i_valid4 = 4'hF; i_data4 = 64'h0004_0003_0002_0001;
    push4(i_data4, 4);
    tick();
    i_valid4 = 4'h0;
    chk("ovr_before", o_ovr4, 1'b0);
    tick();
    i_valid4 = 4'hF; i_data4 = 64'h00EE_00DD_00CC_00BB;
    tick();
    i_valid4 = 4'h0;
    chk("ovr_set", o_ovr4, 1'b1);
    repeat (4) tick();
    chk("ovr_sticky", o_ovr4, 1'b1);
    chk("ovr_busy_end", o_busy4, 1'b0);

    // Mismatch with neuron 0 set: capture proceeds
    reset4();
    chk("mis_cleared", o_mis4, 1'b0);
    i_valid4 = 4'b0111; i_data4 = 64'h000C_000B_000A_0009;
    push4(i_data4, 4);
    tick();
    i_valid4 = 4'h0;
    chk("mis_a_flag", o_mis4, 1'b1);
    repeat (5) tick();
    chk("mis_a_ovr", o_ovr4, 1'b0);

    // Mismatch with neuron 0 clear: nothing captured
    reset4();
    i_valid4 = 4'b1000; i_data4 = 64'h1111_2222_3333_4444;
    tick();
    i_valid4 = 4'h0;
    chk("mis_b_flag", o_mis4, 1'b1);
    chk("mis_b_valid", o_valid4, 1'b0);
    chk("mis_b_busy", o_busy4, 1'b0);
    repeat (3) tick();

    // Reset mid-stream (mismatch flag still set from above)
    i_valid4 = 4'hF; i_data4 = 64'h00A4_00A3_00A2_00A1;
    push4(i_data4, 2);
    tick();
    i_valid4 = 4'h0;
    tick();
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    chk("rstmid_valid", o_valid4, 1'b0);
    chk("rstmid_busy", o_busy4, 1'b0);
    chk("rstmid_mismatch", o_mis4, 1'b0);
    chk("rstmid_overrun", o_ovr4, 1'b0);
    repeat (5) tick();

    // numNeuron = 1: capture on three consecutive edges
    i_valid1 = 1'b1; i_data1 = 16'h00AA;
    push1(i_data1);
    tick();
    i_data1 = 16'h00BB;
    push1(i_data1);
    tick();
    i_data1 = 16'h00CC;
    push1(i_data1);
    tick();
    i_valid1 = 1'b0; i_data1 = '0;
    repeat (3) tick();
    chk("n1_overrun", o_ovr1, 1'b0);
    chk("n1_mismatch", o_mis1, 1'b0);
    chk("n1_busy_end", o_busy1, 1'b0);

    repeat (2) tick();
    chk("n4_queue_drained", q4.size(), 0);
    chk("n1_queue_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
